spi_word_tx: RTL and testbench

// SPI master serializer that sits directly downstream of the test-pattern memory.
// - Consumes the memory's enable (TranSPIen) and registered 12-bit word (data2SPI).
// - Returns a one-cycle next_read pulse each time it latches a word.
// - Shifts each word out on SCLK/MOSI inside its own CS_N frame, toward the CC1200 SPI pins.

---
 rtl/spi_word_tx_if.sv | 29 ++
 rtl/spi_word_tx.sv | 138 +++++++++++++
 tb/tb_spi_word_tx.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_word_tx_if.sv
// spi_word_tx_if: bus between the test-pattern memory, the SPI serializer and
// the CC1200 SPI pins.
//   tran_en    memory -> tx   level enable, high = stream words
//   data_in    memory -> tx   registered word to send (WORD_W bits)
//   next_read  tx -> memory   one-cycle pulse, word latched, advance address
//   spi_sclk   tx -> pins     SPI clock, mode 0
//   spi_mosi   tx -> pins     SPI data out
//   spi_cs_n   tx -> pins     active-low chip select, one word per frame
// modport master: the serializer side. modport slave: memory/pin side.
interface spi_word_tx_if #(
  parameter int WORD_W = 12
);
  logic              tran_en;
  logic [WORD_W-1:0] data_in;
  logic              next_read;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;

  modport master (
    input  tran_en, data_in,
    output next_read, spi_sclk, spi_mosi, spi_cs_n
  );

  modport slave (
    output tran_en, data_in,
    input  next_read, spi_sclk, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/spi_word_tx.sv
// spi_word_tx: SPI mode-0 master that serializes words from the pattern
// memory. One word per CS_N frame, a one-cycle next_read pulse per word.
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   bus       spi_word_tx_if.master (tran_en, data_in, next_read, spi_*)
//   busy      high whenever the FSM is not IDLE
//   word_cnt  words fully transmitted since reset, wraps at 16 bits
// Parameters: WORD_W bits/word, CLK_DIV sclk half period in clk cycles,
//   GAP_CYC CS_N-high cycles in the GAP state between words.
// Build option: define SPI_LSB_FIRST_EN to shift data_in[0] first
//   (default shifts data_in[WORD_W-1] first). Timing is identical.
module spi_word_tx #(
  parameter int WORD_W  = 12,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic          clk,
  input  logic          rstn,
  spi_word_tx_if.master bus,
  output logic          busy,
  output logic [15:0]   word_cnt
);
  localparam int DIV_W = $clog2(2*CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int GAP_W = $clog2(GAP_CYC);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV-1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLK_DIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W-1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC-1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shift_reg, shift_nxt, shift_adv;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              sclk_q, sclk_nxt;
  logic              cs_n_q, cs_n_nxt;
  logic              next_read_q, next_read_nxt;
  logic              busy_nxt;
  logic [15:0]       word_cnt_nxt;

  // mosi is taken straight from the outgoing end of the shift register, so
  // it is registered and drops to 0 when the register is cleared after the
  // last bit.
`ifdef SPI_LSB_FIRST_EN
  assign shift_adv    = {1'b0, shift_reg[WORD_W-1:1]};
  assign bus.spi_mosi = shift_reg[0];
`else
  assign shift_adv    = {shift_reg[WORD_W-2:0], 1'b0};
  assign bus.spi_mosi = shift_reg[WORD_W-1];
`endif

  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.next_read = next_read_q;

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bit_nxt      = bit_cnt;
    div_nxt      = div_cnt;
    gap_nxt      = gap_cnt;
    sclk_nxt     = sclk_q;
    cs_n_nxt     = cs_n_q;
    word_cnt_nxt = word_cnt;
    case (state)
      S_IDLE: if (bus.tran_en) state_nxt = S_WAIT;
      // one spare cycle so the memory's first word has settled on data_in
      S_WAIT: state_nxt = S_LOAD;
      S_LOAD: begin
        shift_nxt = bus.data_in;
        cs_n_nxt  = 1'b0;
        bit_nxt   = '0;
        div_nxt   = '0;
        sclk_nxt  = 1'b0;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          sclk_nxt = 1'b0;
          div_nxt  = '0;
          if (bit_cnt == BIT_LAST) begin
            cs_n_nxt     = 1'b1;
            shift_nxt    = '0;
            word_cnt_nxt = word_cnt + 16'd1;
            gap_nxt      = '0;
            state_nxt    = S_GAP;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            shift_nxt = shift_adv;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
          if (div_cnt == DIV_HALF) sclk_nxt = 1'b1;
        end
      end
      S_GAP: begin
        // tran_en is only looked at on the last gap cycle, so a drop and
        // re-rise inside the gap still counts as enabled
        if (gap_cnt == GAP_LAST) state_nxt = bus.tran_en ? S_LOAD : S_IDLE;
        else                     gap_nxt   = gap_cnt + GAP_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    // registered from the next state so both line up with the state itself
    next_read_nxt = (state_nxt == S_LOAD);
    busy_nxt      = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      next_read_q <= 1'b0;
      busy        <= 1'b0;
      word_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_nxt;
      bit_cnt     <= bit_nxt;
      div_cnt     <= div_nxt;
      gap_cnt     <= gap_nxt;
      sclk_q      <= sclk_nxt;
      cs_n_q      <= cs_n_nxt;
      next_read_q <= next_read_nxt;
      busy        <= busy_nxt;
      word_cnt    <= word_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_spi_word_tx.sv
// tb_spi_word_tx: directed sequence with random words, checked against a
// memory model and an SPI frame decoder. dut runs CLK_DIV=2, dut1 CLK_DIV=1.
module tb_spi_word_tx;
  localparam int W = 12;
`ifdef SPI_LSB_FIRST_EN
  localparam logic [W-1:0] PAT_A5C = 12'h3A5;  // bits in time order, first at MSB
`else
  localparam logic [W-1:0] PAT_A5C = 12'hA5C;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_word_tx_if #(.WORD_W(W)) bus ();
  spi_word_tx_if #(.WORD_W(W)) bus1 ();
  logic        busy, busy1;
  logic [15:0] wc, wc1;

  spi_word_tx #(.WORD_W(W), .CLK_DIV(2), .GAP_CYC(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .word_cnt(wc));
  spi_word_tx #(.WORD_W(W), .CLK_DIV(1), .GAP_CYC(4)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1), .busy(busy1), .word_cnt(wc1));

  int checks = 0;
  int errors = 0;

  // memory model
  logic [W-1:0] mem [16];
  int addr = 0;
  int pend = 0;

  // frame decoder state for dut
  int           cycle = 0;
  int           nr_cyc[$];
  logic [W-1:0] rx_seq[$];
  int           rx_bits[$];
  int           rx_low[$];
  logic [W-1:0] cur_seq = '0;
  int           cur_n = 0, low_cnt = 0, stray = 0;
  int           csr_cyc = 0, busy_fall_cyc = 0;
  logic         p_sclk = 1'b0, p_cs_n = 1'b1, p_busy = 1'b0;

  // decoder state for dut1
  int           nr1 = 0, rises1 = 0, low1 = 0, last1 = 0, pmin1 = 999, pmax1 = 0;
  logic [W-1:0] seq1 = '0;
  logic         p_sclk1 = 1'b0;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // bits in time order -> word, according to the build's bit order
  function automatic logic [W-1:0] to_word(input logic [W-1:0] seq);
`ifdef SPI_LSB_FIRST_EN
    return rev(seq);
`else
    return seq;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: sample on the falling edge, update models, drive inputs
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (!rstn) begin
      cur_n   = 0;
      cur_seq = '0;
      low_cnt = 0;
    end else begin
      if (bus.next_read) begin
        nr_cyc.push_back(cycle);
        addr++;
        pend = 2;
      end
      if (bus.spi_sclk && !p_sclk) begin
        cur_seq = {cur_seq[W-2:0], bus.spi_mosi};
        cur_n++;
        if (bus.spi_cs_n) stray++;
      end
      if (!bus.spi_cs_n) low_cnt++;
      if (bus.spi_cs_n && !p_cs_n) begin
        rx_seq.push_back(cur_seq);
        rx_bits.push_back(cur_n);
        rx_low.push_back(low_cnt);
        csr_cyc = cycle;
        cur_n   = 0;
        cur_seq = '0;
        low_cnt = 0;
      end
      if (!busy && p_busy) busy_fall_cyc = cycle;
      if (bus1.next_read) nr1++;
      if (bus1.spi_sclk && !p_sclk1) begin
        if (rises1 > 0) begin
          if (cycle - last1 < pmin1) pmin1 = cycle - last1;
          if (cycle - last1 > pmax1) pmax1 = cycle - last1;
        end
        last1 = cycle;
        seq1  = {seq1[W-2:0], bus1.spi_mosi};
        rises1++;
      end
      if (!bus1.spi_cs_n) low1++;
    end
    p_sclk  = bus.spi_sclk;
    p_cs_n  = bus.spi_cs_n;
    p_busy  = busy;
    p_sclk1 = bus1.spi_sclk;
    // registered memory: word appears 2 clocks after the address advances
    if (pend > 0) begin
      pend--;
      if (pend == 0) bus.data_in = mem[addr % 16];
    end
  endtask

  task automatic wait_nr(input int n, input string tag);
    int k = 0;
    while (nr_cyc.size() < n && k < 500) begin cyc(); k++; end
    chk(tag, nr_cyc.size() >= n, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 500) begin cyc(); k++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_bits(input int n, input string tag);
    int k = 0;
    while (cur_n < n && k < 500) begin cyc(); k++; end
    chk(tag, cur_n, n);
  endtask

  initial begin
    int t0, wcb, s;
    logic [W-1:0] d1;
    for (int i = 0; i < 16; i++) mem[i] = W'($urandom_range(0, 4095));
    mem[0] = 12'hA5C;
    bus.tran_en = 1'b0; bus.data_in = '0;
    bus1.tran_en = 1'b0; bus1.data_in = '0;

    // reset held while inputs toggle
    repeat (6) begin
      cyc();
      bus.tran_en  = 1'($urandom);
      bus.data_in  = W'($urandom);
      bus1.tran_en = 1'($urandom);
      bus1.data_in = W'($urandom);
    end
    cyc();
    chk("rst_sclk", bus.spi_sclk, 0);
    chk("rst_mosi", bus.spi_mosi, 0);
    chk("rst_cs_n", bus.spi_cs_n, 1);
    chk("rst_next_read", bus.next_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", wc, 0);
    chk("rst_cs_n_div1", bus1.spi_cs_n, 1);
    bus.tran_en = 1'b0; bus1.tran_en = 1'b0;
    bus.data_in = mem[0];
    cyc();
    rstn = 1'b1;
    repeat (3) cyc();

    // single word 0xA5C
    bus.tran_en = 1'b1;
    t0 = cycle;
    wait_nr(1, "a5c_nr_timeout");
    bus.tran_en = 1'b0;
    wait_idle("a5c_idle_timeout");
    chk("a5c_nr_latency", nr_cyc[0] - t0, 2);
    chk("a5c_nr_count", nr_cyc.size(), 1);
    chk("a5c_frames", rx_seq.size(), 1);
    chk("a5c_bit_pattern", rx_seq[0], PAT_A5C);
    chk("a5c_word", to_word(rx_seq[0]), 12'hA5C);
    chk("a5c_rises", rx_bits[0], 12);
    chk("a5c_cs_low", rx_low[0], 48);
    chk("a5c_word_cnt", wc, 1);
    chk("a5c_busy_after_gap", busy_fall_cyc - csr_cyc, 4);

    // three back-to-back random words
    cyc();
    bus.tran_en = 1'b1;
    wait_nr(4, "stream_nr_timeout");
    bus.tran_en = 1'b0;
    wait_idle("stream_idle_timeout");
    chk("stream_period_1", nr_cyc[2] - nr_cyc[1], 53);
    chk("stream_period_2", nr_cyc[3] - nr_cyc[2], 53);
    for (int i = 1; i < 4; i++) begin
      chk("stream_word", to_word(rx_seq[i]), mem[i]);
      chk("stream_cs_low", rx_low[i], 48);
    end
    chk("stream_word_cnt", wc, 4);

    // tran_en drops at the 5th sclk rise: word completes, then idle
    cyc();
    bus.tran_en = 1'b1;
    wait_nr(5, "drop_nr_timeout");
    wait_bits(5, "drop_bits_timeout");
    bus.tran_en = 1'b0;
    wait_idle("drop_idle_timeout");
    repeat (10) cyc();
    chk("drop_word", to_word(rx_seq[4]), mem[4]);
    chk("drop_rises", rx_bits[4], 12);
    chk("drop_no_more_nr", nr_cyc.size(), 5);
    chk("drop_word_cnt", wc, 5);
    chk("drop_busy_after_gap", busy_fall_cyc - csr_cyc, 4);

    // tran_en dips and re-rises inside the gap: streaming continues
    bus.tran_en = 1'b1;
    wait_nr(6, "regap_nr_timeout");
    begin
      int k = 0;
      while (rx_seq.size() < 6 && k < 500) begin cyc(); k++; end
    end
    s = cycle;
    bus.tran_en = 1'b0;
    cyc();
    bus.tran_en = 1'b1;
    wait_nr(7, "regap_nr2_timeout");
    bus.tran_en = 1'b0;
    wait_idle("regap_idle_timeout");
    chk("regap_nr_after_gap", nr_cyc[6] - s, 4);
    chk("regap_period", nr_cyc[6] - nr_cyc[5], 53);
    chk("regap_word", to_word(rx_seq[6]), mem[6]);
    chk("regap_word_cnt", wc, 7);

    // reset in the middle of the 7th bit
    cyc();
    wcb = int'(wc);
    bus.tran_en = 1'b1;
    wait_nr(8, "abort_nr_timeout");
    wait_bits(7, "abort_bits_timeout");
    rstn = 1'b0;
    bus.tran_en = 1'b0;
    cyc();
    chk("abort_cs_n", bus.spi_cs_n, 1);
    chk("abort_sclk", bus.spi_sclk, 0);
    chk("abort_mosi", bus.spi_mosi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_word_cnt", wc, 0);
    rstn = 1'b1;
    repeat (3) cyc();
    bus.tran_en = 1'b1;
    wait_nr(9, "restart_nr_timeout");
    bus.tran_en = 1'b0;
    wait_idle("restart_idle_timeout");
    chk("restart_frames", rx_seq.size(), 8);
    chk("restart_word", to_word(rx_seq[7]), mem[8]);
    chk("restart_rises", rx_bits[7], 12);
    chk("restart_word_cnt", wc, 1);
    chk("no_stray_sclk", stray, 0);
    chk("pre_abort_count", wcb, 7);

    // CLK_DIV=1 instance
    d1 = W'($urandom_range(0, 4095));
    bus1.data_in = d1;
    cyc();
    bus1.tran_en = 1'b1;
    begin
      int k = 0;
      while (nr1 < 1 && k < 100) begin cyc(); k++; end
    end
    bus1.tran_en = 1'b0;
    begin
      int k = 0;
      while ((nr1 < 1 || busy1) && k < 200) begin cyc(); k++; end
    end
    chk("div1_nr", nr1, 1);
    chk("div1_busy", busy1, 0);
    chk("div1_cs_low", low1, 24);
    chk("div1_rises", rises1, 12);
    chk("div1_period_min", pmin1, 2);
    chk("div1_period_max", pmax1, 2);
    chk("div1_word", to_word(seq1), d1);
    chk("div1_word_cnt", wc1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
